// File: rtl/bytebeat_sample_pacer.sv
// Paces a bursty bytebeat sample stream to one sample per divider tick through a small FIFO.
// Optional build macro PACER_MUTE_ON_UNDERRUN_EN: an underrun tick outputs midscale with a strobe.
module bytebeat_sample_pacer #(
  parameter int WIDTH      = 8,
  parameter int CLK_DIV    = 6250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              in_pcm,
  input  logic                          in_vld,
  output logic                          in_rdy,
  output logic [WIDTH-1:0]              sample,
  output logic                          sample_stb,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [FW-1:0]    FULL     = FW'(FIFO_DEPTH);
  localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    fill_q;
  logic [15:0]      div;
  logic             tick;
  logic             push;
  logic             pop;

  // Handshake: a sample transfers on any edge where in_vld && in_rdy; in_rdy depends only on registered fill.
  assign tick   = (div == DIV_LAST);
  assign in_rdy = (fill_q != FULL);
  assign push   = in_vld && in_rdy;
  assign pop    = tick && (fill_q != '0);
  assign fill   = fill_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pcm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_q     <= '0;
      sample     <= MID;
      sample_stb <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      div        <= tick ? 16'd0 : div + 16'd1;
      sample_stb <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      fill_q <= fill_q + FW'(push) - FW'(pop);
      // Pops read the pre-edge head, so a same-cycle push into an empty FIFO is never bypassed.
      if (pop) begin
        sample     <= mem[rd_ptr];
        sample_stb <= 1'b1;
        rd_ptr     <= rd_ptr + 1'b1;
      end else if (tick) begin
        underrun <= 1'b1;
`ifdef PACER_MUTE_ON_UNDERRUN_EN
        sample     <= MID;
        sample_stb <= 1'b1;
`endif
      end
    end
  end

endmodule
